// File: rtl/zigbee_rx_pkg.sv
// Shared types for the receive-side chip path: I/Q pairing state and the
// per-cycle chip command passed from the pairing FSM to the word assembler.
package zigbee_rx_pkg;

    typedef enum logic {EXP_I, EXP_Q} iq_state_t;

    localparam int CHIP_WIDTH_DEF = 32;

    typedef struct packed {
        logic vld;
        logic chip;
        logic round_even;
    } chip_cmd_t;

endpackage : zigbee_rx_pkg

// File: rtl/chip_word_assembler.sv
// Registers the serial chip output and packs chips into a CHIP_WIDTH word,
// chip 0 at bit 0; an ordering error snaps the chip index back to an even slot.
module chip_word_assembler
    import zigbee_rx_pkg::*;
#(
    parameter int CHIP_WIDTH = CHIP_WIDTH_DEF
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_sync,
    input  chip_cmd_t             i_cmd,
    output logic                  o_chip_stream,
    output logic                  o_chip_stream_valid,
    output logic [CHIP_WIDTH-1:0] o_chip_word,
    output logic                  o_chip_word_valid
);

    localparam int               CNT_W = $clog2(CHIP_WIDTH);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(CHIP_WIDTH - 1);

    function automatic logic [CNT_W-1:0] round_down_even(input logic [CNT_W-1:0] c);
        return c & ~CNT_W'(1);
    endfunction

    logic [CNT_W-1:0]      count_q, count_d, base;
    logic [CHIP_WIDTH-1:0] acc_q, acc_d;
    logic [CHIP_WIDTH-1:0] word_q, word_d;
    logic                  word_vld_q, word_vld_d;
    logic                  stream_q, stream_d;
    logic                  stream_vld_q, stream_vld_d;

    always_comb begin
        base         = i_cmd.round_even ? round_down_even(count_q) : count_q;
        count_d      = base;
        acc_d        = acc_q;
        word_d       = word_q;
        word_vld_d   = 1'b0;
        stream_d     = 1'b0;
        stream_vld_d = 1'b0;
        if (i_sync) begin
            count_d = '0;
            acc_d   = '0;
        end else if (i_cmd.vld) begin
            stream_d     = i_cmd.chip;
            stream_vld_d = 1'b1;
            acc_d[base]  = i_cmd.chip;
            if (base == LAST) begin
                word_d     = acc_d;
                word_vld_d = 1'b1;
                count_d    = '0;
            end else begin
                count_d = base + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            count_q      <= '0;
            acc_q        <= '0;
            word_q       <= '0;
            word_vld_q   <= 1'b0;
            stream_q     <= 1'b0;
            stream_vld_q <= 1'b0;
        end else begin
            count_q      <= count_d;
            acc_q        <= acc_d;
            word_q       <= word_d;
            word_vld_q   <= word_vld_d;
            stream_q     <= stream_d;
            stream_vld_q <= stream_vld_d;
        end
    end

    assign o_chip_stream       = stream_q;
    assign o_chip_stream_valid = stream_vld_q;
    assign o_chip_word         = word_q;
    assign o_chip_word_valid   = word_vld_q;

endmodule : chip_word_assembler

// File: rtl/i_q_combiner.sv
// Re-interleaves demodulated I (even) and Q (odd) chips into one serial stream
// and hands each chip to the word assembler; flags I/Q ordering violations.
module i_q_combiner
    import zigbee_rx_pkg::*;
#(
    parameter int CHIP_WIDTH = CHIP_WIDTH_DEF
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_sync,
    input  logic                  i_I_stream,
    input  logic                  i_I_stream_valid,
    input  logic                  i_Q_stream,
    input  logic                  i_Q_stream_valid,
    output logic                  o_ready,
    output logic                  o_chip_stream,
    output logic                  o_chip_stream_valid,
    output logic [CHIP_WIDTH-1:0] o_chip_word,
    output logic                  o_chip_word_valid,
    output logic                  o_err
);

    if (((CHIP_WIDTH % 2) != 0) || (CHIP_WIDTH < 2)) begin : g_bad_chip_width
        $error("i_q_combiner: CHIP_WIDTH must be even and >= 2");
    end

    iq_state_t state_q, state_d;
    logic      hold_q, hold_d;
    logic      hold_valid_q, hold_valid_d;
    logic      err_q, err_d;
    chip_cmd_t cmd;

    // A pending hold blocks new input, so the held Q always drains on the next cycle.
    always_comb begin
        state_d      = state_q;
        hold_d       = hold_q;
        hold_valid_d = 1'b0;
        err_d        = 1'b0;
        cmd          = '0;
        if (i_sync) begin
            state_d = EXP_I;
            hold_d  = 1'b0;
        end else if (hold_valid_q) begin
            cmd.vld  = 1'b1;
            cmd.chip = hold_q;
        end else begin
            case (state_q)
                EXP_I: begin
                    if (i_I_stream_valid) begin
                        cmd.vld  = 1'b1;
                        cmd.chip = i_I_stream;
                        if (i_Q_stream_valid) begin
                            hold_d       = i_Q_stream;
                            hold_valid_d = 1'b1;
                        end else begin
                            state_d = EXP_Q;
                        end
                    end else if (i_Q_stream_valid) begin
                        err_d = 1'b1;
                    end
                end
                EXP_Q: begin
                    if (i_I_stream_valid) begin
                        err_d    = 1'b1;
                        cmd.vld  = 1'b1;
                        cmd.chip = i_I_stream;
                        if (i_Q_stream_valid) begin
                            hold_d       = i_Q_stream;
                            hold_valid_d = 1'b1;
                            state_d      = EXP_I;
                        end else begin
                            state_d = EXP_Q;
                        end
                    end else if (i_Q_stream_valid) begin
                        cmd.vld  = 1'b1;
                        cmd.chip = i_Q_stream;
                        state_d  = EXP_I;
                    end
                end
                default: state_d = EXP_I;
            endcase
        end
        cmd.round_even = err_d;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= EXP_I;
            hold_q       <= 1'b0;
            hold_valid_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
            err_q        <= err_d;
        end
    end

    assign o_ready = ~hold_valid_q;
    assign o_err   = err_q;

    chip_word_assembler #(
        .CHIP_WIDTH (CHIP_WIDTH)
    ) u_asm (
        .i_clk               (i_clk),
        .i_rst_n             (i_rst_n),
        .i_sync              (i_sync),
        .i_cmd               (cmd),
        .o_chip_stream       (o_chip_stream),
        .o_chip_stream_valid (o_chip_stream_valid),
        .o_chip_word         (o_chip_word),
        .o_chip_word_valid   (o_chip_word_valid)
    );

endmodule : i_q_combiner

// File: tb/tb_i_q_combiner.sv
// Directed bench for i_q_combiner: serial and simultaneous I/Q, ordering errors,
// sync realign and asynchronous reset, with hand-computed expected chips and words.
module tb_i_q_combiner;

    localparam int W = 32;

    logic         i_clk = 1'b0;
    logic         i_rst_n = 1'b0;
    logic         i_sync = 1'b0;
    logic         i_I_stream = 1'b0;
    logic         i_I_stream_valid = 1'b0;
    logic         i_Q_stream = 1'b0;
    logic         i_Q_stream_valid = 1'b0;
    logic         o_ready;
    logic         o_chip_stream;
    logic         o_chip_stream_valid;
    logic [W-1:0] o_chip_word;
    logic         o_chip_word_valid;
    logic         o_err;

    int           n_vec = 0;
    int           n_bad = 0;
    int           wv_cnt, chip_cnt, err_cnt;
    logic [W-1:0] last_word;

    i_q_combiner #(.CHIP_WIDTH(W)) dut (
        .i_clk               (i_clk),
        .i_rst_n             (i_rst_n),
        .i_sync              (i_sync),
        .i_I_stream          (i_I_stream),
        .i_I_stream_valid    (i_I_stream_valid),
        .i_Q_stream          (i_Q_stream),
        .i_Q_stream_valid    (i_Q_stream_valid),
        .o_ready             (o_ready),
        .o_chip_stream       (o_chip_stream),
        .o_chip_stream_valid (o_chip_stream_valid),
        .o_chip_word         (o_chip_word),
        .o_chip_word_valid   (o_chip_word_valid),
        .o_err               (o_err)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic clr_stats();
        wv_cnt    = 0;
        chip_cnt  = 0;
        err_cnt   = 0;
        last_word = '0;
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
        if (o_chip_word_valid) begin
            wv_cnt++;
            last_word = o_chip_word;
        end
        if (o_chip_stream_valid) chip_cnt++;
        if (o_err) err_cnt++;
    endtask

    task automatic put(input logic iv, input logic i, input logic qv, input logic q);
        i_I_stream_valid = iv;
        i_I_stream       = i;
        i_Q_stream_valid = qv;
        i_Q_stream       = q;
        step();
    endtask

    task automatic pair_serial(input logic i, input logic q);
        put(1'b1, i, 1'b0, 1'b0);
        put(1'b0, 1'b0, 1'b1, q);
    endtask

    task automatic do_reset();
        i_sync  = 1'b0;
        i_rst_n = 1'b0;
        put(1'b0, 1'b0, 1'b0, 1'b0);
        step();
        chk("rst_ready", o_ready, 1);
        chk("rst_sv", o_chip_stream_valid, 0);
        chk("rst_wv", o_chip_word_valid, 0);
        chk("rst_err", o_err, 0);
        chk("rst_word", o_chip_word, 0);
        i_rst_n = 1'b1;
        step();
        clr_stats();
    endtask

    logic [W-1:0] exp_w;
    logic         kb;

    initial begin
        // 1: alternating serial I/Q
        do_reset();
        put(1, 1, 0, 0);
        chk("t1_sv0", o_chip_stream_valid, 1);
        chk("t1_c0", o_chip_stream, 1);
        put(0, 0, 1, 0);
        chk("t1_c1", {o_chip_stream_valid, o_chip_stream}, 2'b10);
        put(1, 1, 0, 0);
        chk("t1_c2", {o_chip_stream_valid, o_chip_stream}, 2'b11);
        put(0, 0, 1, 1);
        chk("t1_c3", {o_chip_stream_valid, o_chip_stream}, 2'b11);
        put(0, 0, 0, 0);
        chk("t1_idle", o_chip_stream_valid, 0);
        chk("t1_err", err_cnt, 0);

        // 2: simultaneous I/Q, hold drains while ready is low
        do_reset();
        exp_w = '0;
        for (int k = 0; k < 16; k++) begin
            kb = k[0];
            exp_w[2*k]   = kb;
            exp_w[2*k+1] = ~kb;
            put(1, kb, 1, ~kb);
            chk("t2_rdy_lo", o_ready, 0);
            chk("t2_i", {o_chip_stream_valid, o_chip_stream}, {1'b1, kb});
            put(1, kb, 1, kb);
            chk("t2_rdy_hi", o_ready, 1);
            chk("t2_q", {o_chip_stream_valid, o_chip_stream}, {1'b1, ~kb});
        end
        chk("t2_wv_cnt", wv_cnt, 1);
        chk("t2_word", last_word, 32'h6666_6666);
        chk("t2_word_model", last_word, exp_w);
        chk("t2_chips", chip_cnt, 32);
        put(0, 0, 0, 0);
        put(0, 0, 0, 0);
        chk("t2_word_stable", o_chip_word, 32'h6666_6666);
        chk("t2_err", err_cnt, 0);

        // 3: Q first is an error and is dropped
        do_reset();
        put(0, 0, 1, 1);
        chk("t3_err", o_err, 1);
        chk("t3_nochip", o_chip_stream_valid, 0);
        put(1, 1, 1, 1);
        chk("t3_c0", {o_chip_stream_valid, o_chip_stream, o_err}, 3'b110);
        put(0, 0, 0, 0);
        chk("t3_c1", {o_chip_stream_valid, o_chip_stream}, 2'b11);
        for (int k = 0; k < 14; k++) pair_serial(0, 1);
        chk("t3_no_early_wv", wv_cnt, 0);
        pair_serial(0, 1);
        chk("t3_wv_cnt", wv_cnt, 1);
        chk("t3_word", last_word, 32'hAAAA_AAAB);
        chk("t3_err_cnt", err_cnt, 1);

        // 4: sync after 31 chips discards the partial word
        do_reset();
        for (int k = 0; k < 15; k++) pair_serial(1, 0);
        put(1, 1, 0, 0);
        i_sync = 1'b1;
        put(1, 0, 1, 0);
        i_sync = 1'b0;
        chk("t4_sync_sv", o_chip_stream_valid, 0);
        chk("t4_sync_err", o_err, 0);
        chk("t4_sync_wv", wv_cnt, 0);
        for (int k = 0; k < 16; k++) pair_serial(1, 1);
        chk("t4_wv_cnt", wv_cnt, 1);
        chk("t4_word", last_word, 32'hFFFF_FFFF);
        chk("t4_err_cnt", err_cnt, 0);

        // 5: two I in a row; second I takes the even slot again
        do_reset();
        put(1, 1, 0, 0);
        chk("t5_c0", {o_chip_stream_valid, o_chip_stream, o_err}, 3'b110);
        put(1, 0, 0, 0);
        chk("t5_c1", {o_chip_stream_valid, o_chip_stream, o_err}, 3'b101);
        put(0, 0, 1, 1);
        chk("t5_q", {o_chip_stream_valid, o_chip_stream, o_err}, 3'b110);
        for (int k = 0; k < 15; k++) pair_serial(0, 0);
        chk("t5_wv_cnt", wv_cnt, 1);
        chk("t5_word", last_word, 32'h0000_0002);

        // 6: async reset mid-word, then a clean word
        do_reset();
        for (int k = 0; k < 8; k++) pair_serial(1, 1);
        put(1, 1, 0, 0);
        i_I_stream_valid = 1'b0;
        i_rst_n = 1'b0;
        #2;
        chk("t6_ready", o_ready, 1);
        chk("t6_outs", {o_chip_stream_valid, o_chip_stream, o_chip_word_valid, o_err}, 0);
        chk("t6_word", o_chip_word, 0);
        #2;
        i_rst_n = 1'b1;
        step();
        clr_stats();
        for (int k = 0; k < 16; k++) pair_serial(1, 0);
        chk("t6_wv_cnt", wv_cnt, 1);
        chk("t6_word_new", last_word, 32'h5555_5555);

        // 7: I and Q together while expecting Q
        do_reset();
        put(1, 1, 0, 0);
        put(1, 0, 1, 1);
        chk("t7_err_i", {o_chip_stream_valid, o_chip_stream, o_err, o_ready}, 4'b1010);
        put(0, 0, 0, 0);
        chk("t7_held_q", {o_chip_stream_valid, o_chip_stream, o_err, o_ready}, 4'b1101);
        for (int k = 0; k < 15; k++) pair_serial(0, 0);
        chk("t7_wv_cnt", wv_cnt, 1);
        chk("t7_word", last_word, 32'h0000_0002);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule : tb_i_q_combiner
